// File: rtl/sram2r1w_pkg.sv
// Shared types and helpers for the 2R1W SRAM controller.
// SRAM2R1W_CTRL_FWD_EN selects write-before-read forwarding; byte_merge serves that path.
package sram2r1w_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int MAX_DATA_WIDTH = 512;
    localparam int MAX_MASK_WIDTH = MAX_DATA_WIDTH / 8;

    // Callers zero-extend into the wide form and truncate the result back.
    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_MASK_WIDTH-1:0] mask
    );
        logic [MAX_DATA_WIDTH-1:0] result;
        result = old_word;
        for (int b = 0; b < MAX_MASK_WIDTH; b++) begin
            if (mask[b]) result[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/sram2r1w_rd_chan.sv
// One read channel: SRAM latency stage, 2-entry response FIFO with bypass.
// With SRAM2R1W_CTRL_FWD_EN the coincident write is merged into the returned word.
module sram2r1w_rd_chan
    import sram2r1w_pkg::*;
#(
`ifdef SRAM2R1W_CTRL_FWD_EN
    parameter int ADDR_WIDTH = 8,
`endif
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    req_valid,
    output logic                    req_ready,
`ifdef SRAM2R1W_CTRL_FWD_EN
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    wr_fire,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_mask,
`endif
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    input  logic [DATA_WIDTH-1:0]   sram_rdata
);

    logic                  inflight;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic [1:0]            outstanding;
    logic [DATA_WIDTH-1:0] cap_data;
    logic                  req_fire;
    logic                  push;
    logic                  pop;

`ifdef SRAM2R1W_CTRL_FWD_EN
    logic                    fwd_valid_q;
    logic [ADDR_WIDTH-1:0]   fwd_addr_q;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic [DATA_WIDTH-1:0]   fwd_data_q;
    logic [DATA_WIDTH/8-1:0] fwd_mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_q <= 1'b0;
        end else begin
            fwd_valid_q <= wr_fire && req_fire;
        end
        fwd_addr_q <= wr_addr;
        req_addr_q <= req_addr;
        fwd_data_q <= wr_data;
        fwd_mask_q <= wr_mask;
    end

    assign cap_data = (fwd_valid_q && (fwd_addr_q == req_addr_q))
        ? DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(sram_rdata),
                                 MAX_DATA_WIDTH'(fwd_data_q),
                                 MAX_MASK_WIDTH'(fwd_mask_q)))
        : sram_rdata;
`else
    assign cap_data = sram_rdata;
`endif

    assign outstanding = {1'b0, inflight} + count;
    assign rsp_valid   = inflight || (count != 2'd0);
    assign rsp_data    = (count != 2'd0) ? fifo_mem[rd_ptr] : cap_data;
    assign req_ready   = en && ((outstanding < 2'd2) || (rsp_valid && rsp_ready));
    assign req_fire    = req_valid && req_ready;
    assign pop         = (count != 2'd0) && rsp_ready;
    // Arriving data skips the FIFO only when it is empty and the client takes it now.
    assign push        = inflight && !((count == 2'd0) && rsp_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            inflight <= req_fire;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= cap_data;
    end

endmodule

// File: rtl/sram2r1w_ctrl.sv
// Initiator-side controller for a 2-read/1-write SRAM: zero-init sweep, write pass-through, two read channels.
// Define SRAM2R1W_CTRL_FWD_EN for write-before-read on same-cycle address collisions.
module sram2r1w_ctrl
    import sram2r1w_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,

    input  logic                  rd0_req_valid,
    output logic                  rd0_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd0_req_addr,
    output logic                  rd0_rsp_valid,
    input  logic                  rd0_rsp_ready,
    output logic [DATA_WIDTH-1:0] rd0_rsp_data,

    input  logic                  rd1_req_valid,
    output logic                  rd1_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd1_req_addr,
    output logic                  rd1_rsp_valid,
    input  logic                  rd1_rsp_ready,
    output logic [DATA_WIDTH-1:0] rd1_rsp_data,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [MASK_WIDTH-1:0] wr_mask,

    output logic [ADDR_WIDTH-1:0] sram_raddr,
    output logic [ADDR_WIDTH-1:0] sram_raddr2,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata2,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_waddr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic [MASK_WIDTH-1:0] sram_wmask
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  sweeping;
    logic                  run;
    logic                  wr_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + ADDR_WIDTH'(1);
                    if (&init_cnt) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: init_done <= 1'b1;
                default: state <= ST_INIT;
            endcase
        end
    end

    // Gating with rst keeps every handshake and the write strobe quiet during the reset cycle.
    assign sweeping = (state == ST_INIT) && !rst;
    assign run      = (state == ST_RUN) && !rst;
    assign wr_ready = run;
    assign wr_fire  = run && wr_valid;

    assign sram_we     = sweeping || wr_fire;
    assign sram_waddr  = (state == ST_INIT) ? init_cnt : wr_addr;
    assign sram_wdata  = (state == ST_INIT) ? '0 : wr_data;
    assign sram_wmask  = (state == ST_INIT) ? '1 : wr_mask;
    assign sram_raddr  = rd0_req_addr;
    assign sram_raddr2 = rd1_req_addr;

    sram2r1w_rd_chan #(
`ifdef SRAM2R1W_CTRL_FWD_EN
        .ADDR_WIDTH (ADDR_WIDTH),
`endif
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd0 (
        .clk        (clk),
        .rst        (rst),
        .en         (run),
        .req_valid  (rd0_req_valid),
        .req_ready  (rd0_req_ready),
`ifdef SRAM2R1W_CTRL_FWD_EN
        .req_addr   (rd0_req_addr),
        .wr_fire    (wr_fire),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
`endif
        .rsp_valid  (rd0_rsp_valid),
        .rsp_ready  (rd0_rsp_ready),
        .rsp_data   (rd0_rsp_data),
        .sram_rdata (sram_rdata)
    );

    sram2r1w_rd_chan #(
`ifdef SRAM2R1W_CTRL_FWD_EN
        .ADDR_WIDTH (ADDR_WIDTH),
`endif
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd1 (
        .clk        (clk),
        .rst        (rst),
        .en         (run),
        .req_valid  (rd1_req_valid),
        .req_ready  (rd1_req_ready),
`ifdef SRAM2R1W_CTRL_FWD_EN
        .req_addr   (rd1_req_addr),
        .wr_fire    (wr_fire),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
`endif
        .rsp_valid  (rd1_rsp_valid),
        .rsp_ready  (rd1_rsp_ready),
        .rsp_data   (rd1_rsp_data),
        .sram_rdata (sram_rdata2)
    );

endmodule

// File: tb/tb_sram2r1w_ctrl.sv
// Directed bench for sram2r1w_ctrl with a behavioural 2R1W SRAM (1-cycle read latency).
// Expected collision results follow SRAM2R1W_CTRL_FWD_EN.
module tb_sram2r1w_ctrl;

    logic        clk;
    logic        rst;
    logic        init_done;
    logic        rd0_req_valid, rd0_req_ready, rd0_rsp_valid, rd0_rsp_ready;
    logic [7:0]  rd0_req_addr;
    logic [31:0] rd0_rsp_data;
    logic        rd1_req_valid, rd1_req_ready, rd1_rsp_valid, rd1_rsp_ready;
    logic [7:0]  rd1_req_addr;
    logic [31:0] rd1_rsp_data;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic [7:0]  sram_raddr, sram_raddr2, sram_waddr;
    logic [31:0] sram_rdata, sram_rdata2, sram_wdata;
    logic        sram_we;
    logic [3:0]  sram_wmask;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_mem [256];
    logic [31:0] mem [256];
    logic        mem_scramble;

`ifdef SRAM2R1W_CTRL_FWD_EN
    localparam logic [31:0] EXP_COLL_FULL = 32'h12345678;
    localparam logic [31:0] EXP_COLL_PART = 32'h12FEF078;
`else
    localparam logic [31:0] EXP_COLL_FULL = 32'h00000000;
    localparam logic [31:0] EXP_COLL_PART = 32'h12345678;
`endif

    sram2r1w_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .init_done     (init_done),
        .rd0_req_valid (rd0_req_valid),
        .rd0_req_ready (rd0_req_ready),
        .rd0_req_addr  (rd0_req_addr),
        .rd0_rsp_valid (rd0_rsp_valid),
        .rd0_rsp_ready (rd0_rsp_ready),
        .rd0_rsp_data  (rd0_rsp_data),
        .rd1_req_valid (rd1_req_valid),
        .rd1_req_ready (rd1_req_ready),
        .rd1_req_addr  (rd1_req_addr),
        .rd1_rsp_valid (rd1_rsp_valid),
        .rd1_rsp_ready (rd1_rsp_ready),
        .rd1_rsp_data  (rd1_rsp_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_mask       (wr_mask),
        .sram_raddr    (sram_raddr),
        .sram_raddr2   (sram_raddr2),
        .sram_rdata    (sram_rdata),
        .sram_rdata2   (sram_rdata2),
        .sram_we       (sram_we),
        .sram_waddr    (sram_waddr),
        .sram_wdata    (sram_wdata),
        .sram_wmask    (sram_wmask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    // SRAM macro model; starts full of garbage so the zero sweep is observable.
    always @(posedge clk) begin
        sram_rdata  <= mem[sram_raddr];
        sram_rdata2 <= mem[sram_raddr2];
        if (mem_scramble) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5A5A5;
        end else if (sram_we) begin
            mem[sram_waddr] <= merge32(mem[sram_waddr], sram_wdata, sram_wmask);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!init_done && n < 300);
        chk(tag, 32'(n), 32'd256);
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    endtask

    task automatic wr_op(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m,
                         input string tag);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
        #1;
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        chk({tag, "_sram_we"}, 32'(sram_we), 32'd1);
        chk({tag, "_sram_waddr"}, 32'(sram_waddr), 32'(a));
        chk({tag, "_sram_wdata"}, sram_wdata, d);
        chk({tag, "_sram_wmask"}, 32'(sram_wmask), 32'(m));
        tick();
        wr_valid = 1'b0;
        ref_mem[a] = merge32(ref_mem[a], d, m);
    endtask

    task automatic rd_one(input int port, input logic [7:0] a, input logic [31:0] exp,
                          input string tag);
        if (port == 0) begin rd0_req_valid = 1'b1; rd0_req_addr = a; end
        else begin rd1_req_valid = 1'b1; rd1_req_addr = a; end
        #1;
        chk({tag, "_req_ready"}, 32'((port == 0) ? rd0_req_ready : rd1_req_ready), 32'd1);
        chk({tag, "_no_early_rsp"}, 32'((port == 0) ? rd0_rsp_valid : rd1_rsp_valid), 32'd0);
        tick();
        rd0_req_valid = 1'b0;
        rd1_req_valid = 1'b0;
        chk({tag, "_rsp_valid"}, 32'((port == 0) ? rd0_rsp_valid : rd1_rsp_valid), 32'd1);
        chk({tag, "_rsp_data"}, (port == 0) ? rd0_rsp_data : rd1_rsp_data, exp);
        tick();
        chk({tag, "_rsp_done"}, 32'((port == 0) ? rd0_rsp_valid : rd1_rsp_valid), 32'd0);
    endtask

    initial begin
        logic [7:0]  a0, a1;
        logic [31:0] e0, e1;

        rst = 1'b1; mem_scramble = 1'b1;
        rd0_req_valid = 1'b0; rd0_req_addr = 8'h0; rd0_rsp_ready = 1'b0;
        rd1_req_valid = 1'b0; rd1_req_addr = 8'h0; rd1_rsp_ready = 1'b0;
        wr_valid = 1'b0; wr_addr = 8'h0; wr_data = 32'h0; wr_mask = 4'h0;
        tick();
        mem_scramble = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rd0_req_ready", 32'(rd0_req_ready), 32'd0);
        chk("rst_rd1_req_ready", 32'(rd1_req_ready), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_sram_we", 32'(sram_we), 32'd0);
        chk("rst_rd0_rsp_valid", 32'(rd0_rsp_valid), 32'd0);
        chk("rst_rd1_rsp_valid", 32'(rd1_rsp_valid), 32'd0);

        rst = 1'b0;
        #1;
        chk("init_sram_we", 32'(sram_we), 32'd1);
        chk("init_sram_waddr", 32'(sram_waddr), 32'h0);
        chk("init_sram_wdata", sram_wdata, 32'h0);
        chk("init_sram_wmask", 32'(sram_wmask), 32'hF);
        chk("init_wr_ready", 32'(wr_ready), 32'd0);
        wait_init("init_cycles");
        chk("run_sram_we_idle", 32'(sram_we), 32'd0);

        rd0_rsp_ready = 1'b1;
        rd1_rsp_ready = 1'b1;
        rd_one(0, 8'h7F, 32'h00000000, "rd_zero_7f");
        rd_one(1, 8'hFF, 32'h00000000, "rd_zero_ff");

        // Byte-masked writes, then a zero-mask write that must change nothing
        wr_op(8'h10, 32'hDEADBEEF, 4'hF, "wr_full");
        wr_op(8'h10, 32'h000000AA, 4'h1, "wr_byte0");
        rd_one(0, 8'h10, 32'hDEADBEAA, "rd_masked");
        wr_op(8'h10, 32'hFFFFFFFF, 4'h0, "wr_nomask");
        rd_one(1, 8'h10, 32'hDEADBEAA, "rd_after_nomask");

        // Same address on both read ports in one cycle
        rd0_req_valid = 1'b1; rd0_req_addr = 8'h10;
        rd1_req_valid = 1'b1; rd1_req_addr = 8'h10;
        tick();
        rd0_req_valid = 1'b0; rd1_req_valid = 1'b0;
        chk("dual_rd0", rd0_rsp_data, 32'hDEADBEAA);
        chk("dual_rd1", rd1_rsp_data, 32'hDEADBEAA);
        tick();

        // Same-cycle write/read collisions
        wr_valid = 1'b1; wr_addr = 8'h20; wr_data = 32'h12345678; wr_mask = 4'hF;
        rd1_req_valid = 1'b1; rd1_req_addr = 8'h20;
        tick();
        wr_valid = 1'b0; rd1_req_valid = 1'b0;
        chk("coll_full_rd1", rd1_rsp_data, EXP_COLL_FULL);
        tick();
        rd_one(1, 8'h20, 32'h12345678, "rd_after_coll");
        wr_valid = 1'b1; wr_addr = 8'h20; wr_data = 32'hCAFEF00D; wr_mask = 4'h6;
        rd0_req_valid = 1'b1; rd0_req_addr = 8'h20;
        tick();
        wr_valid = 1'b0; rd0_req_valid = 1'b0;
        chk("coll_part_rd0", rd0_rsp_data, EXP_COLL_PART);
        tick();
        rd_one(0, 8'h20, 32'h12FEF078, "rd_after_part");

        // Fill the array with a distinct pattern per address
        wr_valid = 1'b1; wr_mask = 4'hF;
        for (int i = 0; i < 256; i++) begin
            wr_addr = 8'(i);
            wr_data = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'(i)};
            ref_mem[i] = wr_data;
            tick();
        end
        wr_valid = 1'b0;

        // Backpressure on rd0: two outstanding, third held off, drained in order
        rd0_rsp_ready = 1'b0;
        rd0_req_valid = 1'b1; rd0_req_addr = 8'd1;
        #1; chk("bp_accept1", 32'(rd0_req_ready), 32'd1);
        tick();
        rd0_req_addr = 8'd2;
        #1; chk("bp_accept2", 32'(rd0_req_ready), 32'd1);
        chk("bp_valid_b", 32'(rd0_rsp_valid), 32'd1);
        chk("bp_data_b", rd0_rsp_data, 32'h01FE5B01);
        tick();
        rd0_req_addr = 8'd3;
        #1; chk("bp_block3_c", 32'(rd0_req_ready), 32'd0);
        chk("bp_hold_c", rd0_rsp_data, 32'h01FE5B01);
        tick();
        chk("bp_block3_d", 32'(rd0_req_ready), 32'd0);
        chk("bp_hold_d", rd0_rsp_data, 32'h01FE5B01);
        chk("bp_valid_d", 32'(rd0_rsp_valid), 32'd1);
        rd0_rsp_ready = 1'b1;
        #1; chk("bp_accept3", 32'(rd0_req_ready), 32'd1);
        chk("bp_out1", rd0_rsp_data, 32'h01FE5B01);
        tick();
        rd0_req_valid = 1'b0;
        chk("bp_valid2", 32'(rd0_rsp_valid), 32'd1);
        chk("bp_out2", rd0_rsp_data, 32'h02FD5802);
        tick();
        chk("bp_valid3", 32'(rd0_rsp_valid), 32'd1);
        chk("bp_out3", rd0_rsp_data, 32'h03FC5903);
        tick();
        chk("bp_empty", 32'(rd0_rsp_valid), 32'd0);

        // Back-to-back random reads on both ports
        e0 = 32'h0; e1 = 32'h0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin
                chk("b2b_rd0_valid", 32'(rd0_rsp_valid), 32'd1);
                chk("b2b_rd0_data", rd0_rsp_data, e0);
                chk("b2b_rd1_valid", 32'(rd1_rsp_valid), 32'd1);
                chk("b2b_rd1_data", rd1_rsp_data, e1);
            end
            a0 = 8'($urandom_range(0, 255));
            a1 = 8'($urandom_range(0, 255));
            rd0_req_valid = 1'b1; rd0_req_addr = a0;
            rd1_req_valid = 1'b1; rd1_req_addr = a1;
            e0 = ref_mem[a0];
            e1 = ref_mem[a1];
            #1;
            chk("b2b_rd0_ready", 32'(rd0_req_ready), 32'd1);
            chk("b2b_rd1_ready", 32'(rd1_req_ready), 32'd1);
            tick();
        end
        rd0_req_valid = 1'b0; rd1_req_valid = 1'b0;
        chk("b2b_last_rd0", rd0_rsp_data, e0);
        chk("b2b_last_rd1", rd1_rsp_data, e1);
        tick();
        chk("b2b_drain_rd0", 32'(rd0_rsp_valid), 32'd0);
        chk("b2b_drain_rd1", 32'(rd1_rsp_valid), 32'd0);

        // Reset with two buffered responses
        rd0_rsp_ready = 1'b0;
        rd0_req_valid = 1'b1; rd0_req_addr = 8'd5;
        tick();
        rd0_req_addr = 8'd6;
        tick();
        rd0_req_valid = 1'b0;
        tick();
        chk("mid_buffered_valid", 32'(rd0_rsp_valid), 32'd1);
        chk("mid_full_ready", 32'(rd0_req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("mid_rst_sram_we", 32'(sram_we), 32'd0);
        tick();
        chk("mid_rst_rsp_valid", 32'(rd0_rsp_valid), 32'd0);
        chk("mid_rst_init_done", 32'(init_done), 32'd0);
        rst = 1'b0;
        wait_init("reinit_cycles");
        rd0_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("no_stale_rsp", 32'(rd0_rsp_valid), 32'd0);
            tick();
        end
        rd_one(0, 8'd5, 32'h00000000, "rd_after_reinit");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
